// File: rtl/clk_div_mon_if.sv
// Signal bundle between a divided-clock source and the clk_div_mon monitor.
// The master side drives the divided clock and the expected period. The
// slave side (the monitor) returns its measurements and status flags.
interface clk_div_mon_if #(
  parameter int CNT_W = 8
) ();

  logic             div_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             period_err;
  logic             duty_err;
  logic             stuck;

  modport master (
    output div_in, exp_period,
    input  period, high_time, meas_valid, period_err, duty_err, stuck
  );

  modport slave (
    input  div_in, exp_period,
    output period, high_time, meas_valid, period_err, duty_err, stuck
  );

endinterface

// File: rtl/clk_div_mon.sv
// Divided-clock monitor. div_in is sampled as ordinary data in the clk
// domain. The block measures the rise-to-rise period and the high time of
// each div_in cycle, flags period and duty errors, and raises stuck when
// no rising edge arrives within TIMEOUT clk cycles.
//
// Cycle accounting: the cycle in which a rise is detected is t. The
// measurement closed by that rise, and both error flags, all become
// visible together in cycle t+1. The timeout cycle is the one in which the
// rise-free cycle count reaches TIMEOUT, and stuck shows in the cycle
// after it.
module clk_div_mon #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_mon_if.slave mon
);

  typedef enum logic {
    IDLE,  // waiting for a first rise; nothing to measure yet
    MEAS   // counting between two rises
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             d_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;       // cycles since last rise (or since reset / timeout)
  logic [CNT_W-1:0] high_q;      // high cycles since last rise, rise cycle included
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             meas_valid_q;
  logic             period_err_q;
  logic             duty_err_q;
  logic             stuck_q;

  logic             do_meas;
  logic             do_timeout;

  logic [CNT_W:0]   twice_high;
  logic [CNT_W:0]   period_ext;
  logic [CNT_W:0]   duty_diff;
  logic             duty_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Rise detect against last cycle's sample; d_q resets high so a div_in
  // that is already high when reset is released is not taken as a rise.
  assign rise = mon.div_in & ~d_q;

  // Register the previous div_in sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) d_q <= 1'b1;
    else       d_q <= mon.div_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control. A rise always beats a timeout that
  // falls in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_d    = state_q;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
        end else if (cnt_q == TIMEOUT_C) begin
          do_timeout = 1'b1;
        end
      end
      MEAS: begin
        if (rise) begin
          do_meas = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          do_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Duty check |2*high - period| > 1, one bit wider so 2*high cannot overflow.
  always_comb begin
    twice_high = {high_q, 1'b0};
    period_ext = {1'b0, cnt_q};
    duty_diff  = (twice_high >= period_ext) ? (twice_high - period_ext)
                                            : (period_ext - twice_high);
    duty_bad   = (duty_diff > (CNT_W+1)'(1));
  end

  // Saturating cycle and high-time counters; both restart on each rise so
  // they already include the rise cycle itself.
  always_ff @(posedge clk) begin
    if (reset || do_timeout) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else if (rise) begin
      cnt_q  <= CNT_ONE;
      high_q <= CNT_ONE;
    end else begin
      cnt_q  <= sat_inc(cnt_q);
      if (mon.div_in) high_q <= sat_inc(high_q);
    end
  end

  // Capture a measurement and its error flags on each closing rise; the
  // values hold until the next measurement. A timeout leaves them intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      duty_err_q   <= 1'b0;
    end else begin
      meas_valid_q <= do_meas;
      if (do_meas) begin
        period_q     <= cnt_q;
        high_time_q  <= high_q;
        period_err_q <= (cnt_q != mon.exp_period);
        duty_err_q   <= duty_bad;
      end
    end
  end

  // Stuck is set by a timeout and cleared by the next rise.
  always_ff @(posedge clk) begin
    if (reset)           stuck_q <= 1'b0;
    else if (rise)       stuck_q <= 1'b0;
    else if (do_timeout) stuck_q <= 1'b1;
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.period_err = period_err_q;
  assign mon.duty_err   = duty_err_q;
  assign mon.stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// Bench for clk_div_mon. Two instances share clk, reset and div_in: the
// main one (CNT_W=8, TIMEOUT=20) and a narrow one (CNT_W=4, TIMEOUT=15)
// that is only inspected in test_wrap. A model of the main monitor pushes
// the expected measurement when a closing rise is driven. The next cycle
// must show meas_valid, and the expected entry is then popped and compared.
module tb_clk_div_mon;

  localparam int TIMEOUT  = 20;
  localparam int TIMEOUT4 = 15;

  typedef struct packed {
    logic [7:0] period;
    logic [7:0] high;
    logic       perr;
    logic       derr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clk_div_mon_if #(.CNT_W(8)) ifc  ();
  clk_div_mon_if #(.CNT_W(4)) ifc4 ();

  clk_div_mon #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (ifc)
  );

  clk_div_mon #(.CNT_W(4), .TIMEOUT(TIMEOUT4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .mon   (ifc4)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the main instance.
  bit m_live  = 1'b0;  // outputs are defined (a reset edge has happened)
  bit m_armed = 1'b0;  // a previous rise exists to measure from
  bit m_prev  = 1'b1;  // previous div_in sample
  bit m_due   = 1'b0;  // meas_valid expected in the next sampled cycle
  int m_since = 0;     // rise-free cycles counted toward the timeout
  int m_cyc   = 0;     // driven cycle number
  int m_last  = 0;     // cycle number of the last rise
  int m_high  = 0;     // high cycles since the last rise, rise included

  // One clk cycle: check the outputs left by the previous edge, then drive
  // the inputs for the next edge and advance the model.
  task automatic step(input logic v, input logic rst);
    exp_t e;
    int   p;
    int   d;
    @(negedge clk);
    if (m_live) begin
      checks++;
      if (ifc.meas_valid !== m_due) begin
        errors++;
        $display("FAIL meas_valid_timing: got %b expected %b at %0t", ifc.meas_valid, m_due, $time);
      end
      if (ifc.meas_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: meas_valid with no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          if ({ifc.period, ifc.high_time, ifc.period_err, ifc.duty_err} !== e) begin
            errors++;
            $display("FAIL measurement: got period=%0d high=%0d perr=%b derr=%b expected period=%0d high=%0d perr=%b derr=%b at %0t",
                     ifc.period, ifc.high_time, ifc.period_err, ifc.duty_err,
                     e.period, e.high, e.perr, e.derr, $time);
          end
        end
      end
    end
    reset      = rst;
    ifc.div_in  = v;
    ifc4.div_in = v;
    m_due = 1'b0;
    m_cyc++;
    if (rst) begin
      m_live  = 1'b1;
      m_armed = 1'b0;
      m_prev  = 1'b1;
      m_since = 0;
      m_high  = 0;
      sb.delete();
    end else if (v && !m_prev) begin
      m_prev = v;
      if (m_armed) begin
        p = m_cyc - m_last;
        d = 2 * m_high - p;
        if (d < 0) d = -d;
        e.period = 8'(p);
        e.high   = 8'(m_high);
        e.perr   = (p != int'(ifc.exp_period));
        e.derr   = (d > 1);
        sb.push_back(e);
        m_due = 1'b1;
      end
      m_armed = 1'b1;
      m_last  = m_cyc;
      m_high  = 1;
      m_since = 1;
    end else begin
      m_prev = v;
      if (m_since == TIMEOUT) begin
        m_armed = 1'b0;
        m_since = 0;
      end else begin
        m_since++;
      end
      if (v) m_high++;
    end
  endtask

  task automatic drive(input logic v);
    step(v, 1'b0);
  endtask

  // n periods of P cycles, the first H of them high.
  task automatic periods(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        drive(i < h);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b0, 1'b1);
    checks++;
    if ({ifc.period, ifc.high_time, ifc.meas_valid, ifc.period_err, ifc.duty_err, ifc.stuck} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: got period=%0d high=%0d mv=%b perr=%b derr=%b stuck=%b expected all zero",
               ifc.period, ifc.high_time, ifc.meas_valid, ifc.period_err, ifc.duty_err, ifc.stuck);
    end
    // div_in already high across reset release must not count as a rise.
    step(1'b1, 1'b1);
    repeat (3) drive(1'b1);
    drive(1'b0);
  endtask

  task automatic test_basic();
    ifc.exp_period = 8'd4;
    periods(4, 2, 6);
    checks++;
    if ({ifc.period, ifc.high_time, ifc.period_err, ifc.duty_err} !== {8'd4, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_hold: got period=%0d high=%0d perr=%b derr=%b expected 4 2 0 0",
               ifc.period, ifc.high_time, ifc.period_err, ifc.duty_err);
    end
  endtask

  task automatic test_duty();
    ifc.exp_period = 8'd5;
    periods(5, 3, 4);
    checks++;
    if (ifc.duty_err !== 1'b0) begin
      errors++;
      $display("FAIL duty_ok: got duty_err=%b expected 0", ifc.duty_err);
    end
    periods(5, 4, 4);
    checks++;
    if ({ifc.high_time, ifc.duty_err} !== {8'd4, 1'b1}) begin
      errors++;
      $display("FAIL duty_bad: got high=%0d duty_err=%b expected 4 1", ifc.high_time, ifc.duty_err);
    end
  endtask

  task automatic test_period_err();
    ifc.exp_period = 8'd4;
    periods(6, 3, 4);
    checks++;
    if ({ifc.period, ifc.period_err} !== {8'd6, 1'b1}) begin
      errors++;
      $display("FAIL period_err_set: got period=%0d perr=%b expected 6 1", ifc.period, ifc.period_err);
    end
    ifc.exp_period = 8'd6;
    periods(6, 3, 3);
    checks++;
    if (ifc.period_err !== 1'b0) begin
      errors++;
      $display("FAIL period_err_clear: got perr=%b expected 0", ifc.period_err);
    end
    ifc.exp_period = 8'd0;
    periods(6, 3, 2);
    checks++;
    if (ifc.period_err !== 1'b1) begin
      errors++;
      $display("FAIL exp_zero: got perr=%b expected 1", ifc.period_err);
    end
    ifc.exp_period = 8'd6;
  endtask

  task automatic test_stuck();
    logic want;
    drive(1'b1);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      drive(1'b0);
      want = (i == TIMEOUT + 1);
      checks++;
      if (ifc.stuck !== want) begin
        errors++;
        $display("FAIL stuck_timing: cycle %0d after rise got stuck=%b expected %b", i, ifc.stuck, want);
      end
    end
    checks++;
    if (ifc.period !== 8'd6) begin
      errors++;
      $display("FAIL stuck_keeps_period: got period=%0d expected 6", ifc.period);
    end
    repeat (3) drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    checks++;
    if (ifc.stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear: got stuck=%b expected 0", ifc.stuck);
    end
    repeat (4) drive(1'b0);
    drive(1'b1);
    // A rise landing exactly in the timeout cycle wins.
    repeat (TIMEOUT - 1) drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    checks++;
    if ({ifc.stuck, ifc.period} !== {1'b0, 8'(TIMEOUT)}) begin
      errors++;
      $display("FAIL rise_wins: got stuck=%b period=%0d expected 0 %0d", ifc.stuck, ifc.period, TIMEOUT);
    end
    drive(1'b0);
  endtask

  task automatic test_mid_reset();
    ifc.exp_period = 8'd4;
    periods(4, 2, 3);
    drive(1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if ({ifc.period, ifc.high_time, ifc.meas_valid, ifc.period_err, ifc.duty_err, ifc.stuck} !== 20'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got period=%0d high=%0d mv=%b perr=%b derr=%b stuck=%b expected all zero",
               ifc.period, ifc.high_time, ifc.meas_valid, ifc.period_err, ifc.duty_err, ifc.stuck);
    end
    drive(1'b0);
    drive(1'b0);
    periods(4, 2, 3);
  endtask

  task automatic test_wrap();
    logic want;
    ifc.exp_period = 8'd6;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        drive(i < 10);
        want = (i >= TIMEOUT4 + 1) || (k > 0 && i == 0);
        checks++;
        if ({ifc4.stuck, ifc4.meas_valid, ifc4.period} !== {want, 1'b0, 4'd0}) begin
          errors++;
          $display("FAIL narrow_stuck: period %0d cycle %0d got stuck=%b mv=%b period=%0d expected %b 0 0",
                   k, i, ifc4.stuck, ifc4.meas_valid, ifc4.period, want);
        end
      end
    end
    repeat (2) drive(1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    ifc.div_in      = 1'b0;
    ifc.exp_period  = 8'd4;
    ifc4.div_in     = 1'b0;
    ifc4.exp_period = 4'd0;
    test_reset();
    test_basic();
    test_duty();
    test_period_err();
    test_stuck();
    test_mid_reset();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected measurements never seen, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
